ss_scan_controller: RTL and testbench
=====================================

Name: ss_scan_controller

Overview:
- Time-multiplexing scan controller for the 4-digit common-anode seven-segment display.
- Consumes the four per-digit 7-bit segment patterns produced by the segment decoder (active-low, bit order g..a).
- Drives one shared segment/dp bus plus four active-low anodes, one digit at a time.
- Adds per-slot dead time (anti-ghosting), frame-synchronous input snapshot (no tearing), per-digit blanking, decimal points and blinking.

Parameters:
- DIGIT_CYC, 25000, clk cycles per digit slot (1 kHz/digit at 25 MHz); must be >= 2.
- DEAD_CYC, 250, cycles at the start of each slot with all anodes off; 0 <= DEAD_CYC < DIGIT_CYC.
- BLINK_FRAMES, 64, frames per blink half-period; must be >= 1.

Ports:
- clk  input  1  25 MHz system clock.
- rst  input  1  synchronous active-high reset.
- seg3  input  7  segment pattern for the leftmost digit, active-low.
- seg2  input  7  segment pattern for digit 2, active-low.
- seg1  input  7  segment pattern for digit 1, active-low.
- seg0  input  7  segment pattern for the rightmost digit, active-low.
- dp_en  input  4  decimal point enable per digit, bit i = digit i, active-high.
- blank_mask  input  4  force digit i dark when bit i = 1.
- blink_en  input  4  digit i blinks when bit i = 1.
- an  output  4  anode enables, active-low, one-hot-low or all-high.
- seg  output  7  shared segment bus, active-low.
- dp  output  1  decimal point, active-low.
- frame_start  output  1  one-cycle pulse when the slot of digit 0 begins.

Behaviour:
- Reset (sync, rst=1 at a posedge):
  - an=4'b1111, seg=7'h7F, dp=1, frame_start=0.
  - slot counter cnt=0, digit index idx=0, blink phase=0, frame counter=0, snapshot registers cleared to dark (seg 7'h7F, dp_en/blank/blink 0).
  - Reset asserted mid-scan produces the same state on the next edge; no partial digit remains lit.
- Slot timing:
  - cnt counts 0..DIGIT_CYC-1, then wraps to 0 and idx increments 0->1->2->3->0.
  - Phase DEAD while cnt < DEAD_CYC; phase LIT otherwise. With DEAD_CYC=0 there is no DEAD phase.
- Snapshot:
  - At every internal cycle with idx=0 and cnt=0 (including the first cycle after reset), seg0..seg3, dp_en, blank_mask and blink_en are captured.
  - The display uses only the snapshot. Input changes at any other time take effect at the next frame start.
- Blink:
  - The frame counter increments at each frame start. When it reaches BLINK_FRAMES-1 it wraps to 0 and the blink phase toggles.
  - The blink phase changes only at frame boundaries.
- Output generation, registered with one cycle of latency from the internal (idx, cnt) state:
  - DEAD phase: an=1111, seg=7'h7F, dp=1.
  - LIT phase with digit dark (snap_blank[idx] or (snap_blink[idx] and blink phase=1)): an=1111, seg=7'h7F, dp=1. The slot timing is unchanged.
  - LIT phase otherwise: an has bit idx=0 and all other bits 1; seg=snap_seg[idx]; dp=~snap_dp[idx].
- frame_start is a registered pulse, aligned with the first output cycle of digit 0's slot.
- Invariant: at most one an bit is 0 in any cycle, and seg/dp change only while an=1111.
- Frame length = 4*DIGIT_CYC cycles, exact and jitter-free.

Decomposition:
- Shared package ss_pkg:
  - SEG_OFF=7'h7F, AN_OFF=4'hF.
  - Phase enum {PH_DEAD, PH_LIT}.
  - Digit index typedef (2 bits).
- One sub-module, ss_blink_gen: frame counter plus phase toggle.
  - Inputs: clk, rst, frame_tick.
  - Output: blink_phase.
  - Parameter: BLINK_FRAMES.

Test Plan:
- Reset/idle: DIGIT_CYC=8, DEAD_CYC=2, segs=7'h40/7'h79/7'h24/7'h30 (0,1,2,3), masks 0, release rst -> an sequence per slot is 1111 x2 then 1110 x6 (seg=7'h30 on digit 0), then 1111 x2 and 1101 x6 (seg=7'h24), and so on; frame_start pulses every 32 cycles.
- Mid-frame input change: change seg0 to 7'h12 while idx=2 -> digit 0 still shows 7'h30 for the rest of that frame and shows 7'h12 from the next frame_start.
- Blank/dp: blank_mask=4'b0100, dp_en=4'b0001 -> digit 2 slot has an=1111 throughout; dp=0 only while an=1110.
- Blink: BLINK_FRAMES=2, blink_en=4'b1000 -> digit 3 lit for frames 0-1, dark for frames 2-3, lit for frames 4-5; other digits always lit.
- Reset mid-operation: assert rst for 1 cycle while an=1011 -> next cycle an=1111, seg=7'h7F; scan restarts at digit 0 with the fresh snapshot.
- Invariant checker across random inputs: never more than one an bit low, and seg/dp transitions occur only while an=1111.

Source files
------------

// File: rtl/ss_pkg.sv
// Shared constants and types for the four-digit seven-segment scan controller.
package ss_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] AN_OFF  = 4'hF;

  typedef enum logic {PH_DEAD, PH_LIT} phase_t;

  typedef logic [1:0] digit_idx_t;

  // Active-low anode pattern with only the selected digit driven.
  function automatic logic [3:0] an_select(input digit_idx_t idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/ss_blink_gen.sv
// Blink phase generator: counts frames and toggles the phase every BLINK_FRAMES frames.
module ss_blink_gen #(
  parameter int BLINK_FRAMES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic frame_tick,
  output logic blink_phase
);

  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  logic [FW-1:0] r_frame_cnt;
  logic          r_phase;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_cnt <= '0;
      r_phase     <= 1'b0;
    end else if (frame_tick) begin
      if (r_frame_cnt == FRAME_LAST) begin
        r_frame_cnt <= '0;
        r_phase     <= ~r_phase;
      end else begin
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end
    end
  end

  assign blink_phase = r_phase;

endmodule

// File: rtl/ss_scan_controller.sv
// Time-multiplexed scan of four common-anode digits with dead time, frame snapshot,
// per-digit blanking, decimal points and blinking; outputs are registered.
module ss_scan_controller
  import ss_pkg::*;
#(
  parameter int DIGIT_CYC    = 25000,
  parameter int DEAD_CYC     = 250,
  parameter int BLINK_FRAMES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg3,
  input  logic [6:0] seg2,
  input  logic [6:0] seg1,
  input  logic [6:0] seg0,
  input  logic [3:0] dp_en,
  input  logic [3:0] blank_mask,
  input  logic [3:0] blink_en,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_start
);

  localparam int CW = $clog2(DIGIT_CYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIGIT_CYC - 1);
  localparam logic [CW-1:0] DEAD_LIM = CW'(DEAD_CYC);

  logic [CW-1:0]   r_cnt;
  digit_idx_t      r_idx;
  logic [3:0][6:0] r_snap_seg;
  logic [3:0]      r_snap_dp;
  logic [3:0]      r_snap_blank;
  logic [3:0]      r_snap_blink;
  logic [3:0]      r_an;
  logic [6:0]      r_seg;
  logic            r_dp;
  logic            r_frame_start;

  logic [3:0][6:0] w_seg_in;
  logic [3:0][6:0] w_snap_seg;
  logic [3:0]      w_snap_dp;
  logic [3:0]      w_snap_blank;
  logic [3:0]      w_snap_blink;
  logic            w_cnt_last;
  logic            w_frame_first;
  logic            w_frame_last;
  logic            w_blink_phase;
  logic            w_dark;
  phase_t          w_phase;
  logic [3:0]      w_an_next;
  logic [6:0]      w_seg_next;
  logic            w_dp_next;

  assign w_seg_in      = {seg3, seg2, seg1, seg0};
  assign w_cnt_last    = (r_cnt == CNT_LAST);
  assign w_frame_first = (r_idx == 2'd0) && (r_cnt == '0);
  assign w_frame_last  = (r_idx == 2'd3) && w_cnt_last;
  assign w_phase       = (r_cnt < DEAD_LIM) ? PH_DEAD : PH_LIT;

  // Phase advances on the last cycle of a frame so a whole frame sees one phase.
  ss_blink_gen #(
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_blink_gen (
    .clk         (clk),
    .rst         (rst),
    .frame_tick  (w_frame_last),
    .blink_phase (w_blink_phase)
  );

  // On the capture cycle the fresh inputs are forwarded so the new frame never mixes snapshots.
  always_comb begin
    w_snap_seg   = w_frame_first ? w_seg_in   : r_snap_seg;
    w_snap_dp    = w_frame_first ? dp_en      : r_snap_dp;
    w_snap_blank = w_frame_first ? blank_mask : r_snap_blank;
    w_snap_blink = w_frame_first ? blink_en   : r_snap_blink;
    w_dark       = w_snap_blank[r_idx] | (w_snap_blink[r_idx] & w_blink_phase);
    w_an_next    = AN_OFF;
    w_seg_next   = SEG_OFF;
    w_dp_next    = 1'b1;
    if ((w_phase == PH_LIT) && !w_dark) begin
      w_an_next  = an_select(r_idx);
      w_seg_next = w_snap_seg[r_idx];
      w_dp_next  = ~w_snap_dp[r_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt         <= '0;
      r_idx         <= 2'd0;
      r_snap_seg    <= {4{SEG_OFF}};
      r_snap_dp     <= 4'b0000;
      r_snap_blank  <= 4'b0000;
      r_snap_blink  <= 4'b0000;
      r_an          <= AN_OFF;
      r_seg         <= SEG_OFF;
      r_dp          <= 1'b1;
      r_frame_start <= 1'b0;
    end else begin
      r_cnt <= w_cnt_last ? '0 : r_cnt + 1'b1;
      if (w_cnt_last) begin
        r_idx <= r_idx + 1'b1;
      end
      if (w_frame_first) begin
        r_snap_seg   <= w_seg_in;
        r_snap_dp    <= dp_en;
        r_snap_blank <= blank_mask;
        r_snap_blink <= blink_en;
      end
      r_an          <= w_an_next;
      r_seg         <= w_seg_next;
      r_dp          <= w_dp_next;
      r_frame_start <= w_frame_first;
    end
  end

  assign an          = r_an;
  assign seg         = r_seg;
  assign dp          = r_dp;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_ss_scan_controller.sv
// Self-checking bench: frame-per-row vector table, mid-frame/reset sequences, random invariant run.
module tb_ss_scan_controller;

  localparam int DIGIT_CYC = 8;
  localparam int DEAD_CYC  = 2;
  localparam int FRAME_CYC = 4 * DIGIT_CYC;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] seg3, seg2, seg1, seg0;
  logic [3:0] dp_en, blank_mask, blink_en;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_start;

  int checks = 0;
  int errors = 0;
  int frame_no = 0;

  always #5 clk = ~clk;

  ss_scan_controller #(
    .DIGIT_CYC    (DIGIT_CYC),
    .DEAD_CYC     (DEAD_CYC),
    .BLINK_FRAMES (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .seg3        (seg3),
    .seg2        (seg2),
    .seg1        (seg1),
    .seg0        (seg0),
    .dp_en       (dp_en),
    .blank_mask  (blank_mask),
    .blink_en    (blink_en),
    .an          (an),
    .seg         (seg),
    .dp          (dp),
    .frame_start (frame_start)
  );

  // One row = one frame: inputs held over the frame start, plus which digits must light.
  typedef struct {
    logic [6:0] s3, s2, s1, s0;
    logic [3:0] dpe, blk, bln;
    logic [3:0] exp_lit;
  } vec_t;

  vec_t rows [10];

  function automatic vec_t mk(input logic [6:0] s3, input logic [6:0] s2, input logic [6:0] s1,
                              input logic [6:0] s0, input logic [3:0] dpe, input logic [3:0] blk,
                              input logic [3:0] bln, input logic [3:0] exp_lit);
    vec_t v;
    v.s3 = s3; v.s2 = s2; v.s1 = s1; v.s0 = s0;
    v.dpe = dpe; v.blk = blk; v.bln = bln; v.exp_lit = exp_lit;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    seg3 = v.s3; seg2 = v.s2; seg1 = v.s1; seg0 = v.s0;
    dp_en = v.dpe; blank_mask = v.blk; blink_en = v.bln;
  endtask

  task automatic check_outputs(input string name, input logic [3:0] exp_an, input logic [6:0] exp_seg,
                               input logic exp_dp, input logic exp_fs);
    checks++;
    if (an !== exp_an || seg !== exp_seg || dp !== exp_dp || frame_start !== exp_fs) begin
      errors++;
      $display("FAIL %s: an/seg/dp/fs got %b/%h/%b/%b want %b/%h/%b/%b",
               name, an, seg, dp, frame_start, exp_an, exp_seg, exp_dp, exp_fs);
    end
  endtask

  // Checks one full frame; at cycle chg_at (if >= 0) seg0/seg3 are changed mid-frame.
  task automatic check_frame(input vec_t v, input int chg_at);
    logic [6:0] segs [4];
    int d, p;
    logic lit;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic e_dp;
    segs[0] = v.s0; segs[1] = v.s1; segs[2] = v.s2; segs[3] = v.s3;
    for (int c = 0; c < FRAME_CYC; c++) begin
      @(negedge clk);
      d = c / DIGIT_CYC;
      p = c % DIGIT_CYC;
      lit = (p >= DEAD_CYC) && v.exp_lit[d];
      e_an  = lit ? ~(4'b0001 << d) : 4'b1111;
      e_seg = lit ? segs[d] : 7'h7F;
      e_dp  = lit ? ~v.dpe[d] : 1'b1;
      check_outputs($sformatf("frame%0d_cyc%0d", frame_no, c), e_an, e_seg, e_dp, c == 0);
      if (c == chg_at) begin
        seg0 = 7'h12;
        seg3 = 7'h5B;
      end
    end
    $display("frame %0d checked: lit=%b dp_en=%b blank=%b blink=%b", frame_no, v.exp_lit, v.dpe, v.blk, v.bln);
    frame_no++;
  endtask

  initial begin
    logic [3:0] prev_an;
    logic [7:0] prev_sd;
    int since_fs;
    logic seen_fs;

    // Blink phase: frames 0,1 lit; 2,3 dark; 4,5 lit; 6,7 dark; 8,9 lit; 10 dark.
    rows[0] = mk(7'h40, 7'h79, 7'h24, 7'h30, 4'b0000, 4'b0000, 4'b0000, 4'b1111);
    rows[1] = mk(7'h40, 7'h79, 7'h24, 7'h30, 4'b0001, 4'b0100, 4'b0000, 4'b1011);
    rows[2] = mk(7'h40, 7'h79, 7'h24, 7'h30, 4'b0000, 4'b0000, 4'b1000, 4'b0111);
    rows[3] = mk(7'h12, 7'h02, 7'h78, 7'h00, 4'b1010, 4'b0000, 4'b1000, 4'b0111);
    rows[4] = mk(7'h12, 7'h02, 7'h78, 7'h00, 4'b0000, 4'b0010, 4'b1001, 4'b1101);
    rows[5] = mk(7'h66, 7'h6D, 7'h7D, 7'h07, 4'b0100, 4'b0000, 4'b1111, 4'b1111);
    rows[6] = mk(7'h66, 7'h6D, 7'h7D, 7'h07, 4'b1111, 4'b0000, 4'b1111, 4'b0000);
    rows[7] = mk(7'h66, 7'h6D, 7'h7D, 7'h07, 4'b1111, 4'b1000, 4'b0101, 4'b0010);
    rows[8] = mk(7'h40, 7'h79, 7'h24, 7'h30, 4'b0000, 4'b0000, 4'b0000, 4'b1111);
    rows[9] = mk(7'h5B, 7'h79, 7'h24, 7'h12, 4'b0000, 4'b0000, 4'b0000, 4'b1111);

    rst = 1'b1;
    apply(rows[0]);
    repeat (2) begin
      @(negedge clk);
      check_outputs("reset_state", 4'b1111, 7'h7F, 1'b1, 1'b0);
    end
    rst = 1'b0;

    for (int f = 0; f < 10; f++) begin
      check_frame(rows[f], (f == 8) ? 2 * DIGIT_CYC : -1);
      if (f < 9) apply(rows[f + 1]);
    end

    // Reset while digit 2 is lit, then restart with a fresh snapshot and cleared blink phase.
    apply(rows[8]);
    for (int c = 0; c < 19; c++) @(negedge clk);
    @(negedge clk);
    checks++;
    if (an !== 4'b1011) begin
      errors++;
      $display("FAIL pre_reset_an: got %b want %b", an, 4'b1011);
    end
    rst = 1'b1;
    seg0 = 7'h66;
    blink_en = 4'b1111;
    @(negedge clk);
    check_outputs("mid_reset", 4'b1111, 7'h7F, 1'b1, 1'b0);
    rst = 1'b0;
    frame_no = 0;
    check_frame(mk(7'h40, 7'h79, 7'h24, 7'h66, 4'b0000, 4'b0000, 4'b1111, 4'b1111), -1);

    // Random inputs every cycle: one-hot-low anodes, glitch-free segments, fixed frame period.
    prev_an = an;
    prev_sd = {seg, dp};
    since_fs = 0;
    seen_fs = 1'b0;
    for (int i = 0; i < 20 * FRAME_CYC; i++) begin
      seg0 = 7'($urandom); seg1 = 7'($urandom); seg2 = 7'($urandom); seg3 = 7'($urandom);
      dp_en = 4'($urandom); blank_mask = 4'($urandom); blink_en = 4'($urandom);
      @(negedge clk);
      since_fs++;
      checks++;
      if ($countones(~an) > 1) begin
        errors++;
        $display("FAIL onehot_an cyc%0d: got %b want at most one low bit", i, an);
      end
      checks++;
      if (({seg, dp} !== prev_sd) && (prev_an !== 4'hF) && (an !== 4'hF)) begin
        errors++;
        $display("FAIL seg_while_lit cyc%0d: seg/dp %h->%h with an %b->%b want an=1111 around change",
                 i, prev_sd, {seg, dp}, prev_an, an);
      end
      if (frame_start) begin
        if (seen_fs) begin
          checks++;
          if (since_fs != FRAME_CYC) begin
            errors++;
            $display("FAIL frame_period cyc%0d: got %0d want %0d", i, since_fs, FRAME_CYC);
          end
        end
        seen_fs = 1'b1;
        since_fs = 0;
      end
      prev_an = an;
      prev_sd = {seg, dp};
    end
    checks++;
    if (!seen_fs) begin
      errors++;
      $display("FAIL frame_start_seen: got 0 want 1");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
